gate_vector_checker: RTL

- Self-contained sequencer/checker placed around a 2-input combinational gate cell.
- Drives the gate's A and B inputs through the four-vector truth-table sequence: 00, then A=1 B=0, then A=0 B=1, then 11.
- Waits a programmable settle time, samples the gate output C, and compares it against an expected truth table.
- Reports pass/fail and an error count. Lets gate cells be checked in-circuit without a hand-written stimulus bench.

---
 rtl/gate_vector_checker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/gate_vector_checker.sv
// Sequencer/checker for a 2-input gate cell: drives {B,A} through 00,01,10,11, settles, samples C and counts mismatches.
// Optional first-failure capture outputs are enabled by defining GATE_CHK_FAILCAP_EN.
module gate_vector_checker #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
`ifdef GATE_CHK_FAILCAP_EN
  ,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_idx
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_vector_checker: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, SAMPLE} state_t;

  state_t     state_q, state_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ff_vld_q, ff_vld_d;
  logic [1:0] ff_idx_q, ff_idx_d;
  logic       mismatch;

  // Case inequality so an X/Z on the gate output is reported as a mismatch.
  assign mismatch = (C !== TRUTH[idx_q]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      ff_vld_q <= 1'b0;
      ff_idx_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ff_vld_q <= ff_vld_d;
      ff_idx_q <= ff_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ff_vld_d = ff_vld_q;
    ff_idx_d = ff_idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          err_d    = 3'd0;
          pass_d   = 1'b0;
          idx_d    = 2'd0;
          ff_vld_d = 1'b0;
          ff_idx_d = 2'd0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        a_d     = idx_q[0];
        b_d     = idx_q[1];
        cnt_d   = SETTLE_INIT;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        err_d = err_q + {2'b00, mismatch};
        if (mismatch && !ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_idx_d = idx_q;
        end
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = DRIVE;
        end else begin
          // Final vector: pass reflects the count including this sample.
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
          idx_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A       = a_q;
  assign B       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_idx = idx_q;

`ifdef GATE_CHK_FAILCAP_EN
  assign first_fail_vld = ff_vld_q;
  assign first_fail_idx = ff_idx_q;
`else
  logic unused_ff;
  assign unused_ff = ff_vld_q ^ (^ff_idx_q);
`endif

endmodule
